formula_window_avg: RTL and testbench

- Downstream stage of the formula pipeline.
- Consumes the signed result stream (`WIDTH*2+3` bits) through a valid/ready handshake.
- Accumulates non-overlapping blocks of `2**LOG2_N` samples and emits:
  - the exact block sum,
  - the block average, by arithmetic shift,
  - the sample count.
- A `flush` pulse emits a partial block early.

---
 rtl/formula_pkg.sv | 14 +
 rtl/formula_window_avg_if.sv | 37 +++
 rtl/formula_avg_shift.sv | 32 +++
 rtl/formula_window_avg.sv | 105 ++++++++++
 tb/tb_formula_window_avg.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/formula_pkg.sv
// formula_pkg: shared width helper and FSM
// state type for the formula pipeline.
package formula_pkg;

  function automatic int in_w(input int width);
    return width * 2 + 3;
  endfunction

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/formula_window_avg_if.sv
// formula_window_avg_if: sample stream in,
// block sum/avg/count stream out.
interface formula_window_avg_if #(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 2
);
  import formula_pkg::*;

  localparam int IN_W = in_w(WIDTH);

  logic signed [IN_W-1:0]        in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          flush;
  logic signed [IN_W+LOG2_N-1:0] out_sum;
  logic signed [IN_W-1:0]        out_avg;
  logic [LOG2_N:0]               out_count;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output in_data, in_valid, flush,
    output out_ready,
    input  in_ready,
    input  out_sum, out_avg, out_count,
    input  out_valid
  );

  modport slave (
    input  in_data, in_valid, flush,
    input  out_ready,
    output in_ready,
    output out_sum, out_avg, out_count,
    output out_valid
  );

endinterface

// File: rtl/formula_avg_shift.sv
// formula_avg_shift: block sum to average.
// FORMULA_AVG_ROUND_EN: round half up, else floor.
module formula_avg_shift #(
  parameter int IN_W   = 19,
  parameter int LOG2_N = 2
) (
  input  logic signed [IN_W+LOG2_N-1:0] sum,
  output logic signed [IN_W-1:0]        avg
);

  localparam int SW = IN_W + LOG2_N;

  if (LOG2_N == 0) begin : g_pass
    assign avg = sum;
  end else begin : g_shift
    // one guard bit keeps the rounding add exact
    logic signed [SW:0] adj;
    logic               unused_bits;
`ifdef FORMULA_AVG_ROUND_EN
    localparam logic signed [SW:0] HALF =
      (SW+1)'(1) <<< (LOG2_N - 1);
    assign adj = (SW+1)'(sum) + HALF;
`else
    assign adj = (SW+1)'(sum);
`endif
    // the shifted result always fits IN_W bits
    assign avg = adj[SW-1:LOG2_N];
    assign unused_bits =
      ^{adj[SW], adj[LOG2_N-1:0]};
  end

endmodule

// File: rtl/formula_window_avg.sv
// formula_window_avg: block sum/average of the
// formula result stream; FORMULA_AVG_ROUND_EN.
module formula_window_avg
  import formula_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 2
) (
  input logic                 clk,
  input logic                 rst,
  formula_window_avg_if.slave bus
);

  localparam int IN_W = in_w(WIDTH);
  localparam int SW   = IN_W + LOG2_N;
  localparam logic [LOG2_N:0] N =
    (LOG2_N+1)'(1) << LOG2_N;

  state_t                state;
  state_t                state_nx;
  logic signed [SW-1:0]  acc;
  logic signed [SW-1:0]  samp;
  logic signed [SW-1:0]  acc_inc;
  logic signed [SW-1:0]  ld_sum;
  logic signed [IN_W-1:0] ld_avg;
  logic [LOG2_N:0]       cnt;
  logic [LOG2_N:0]       cnt_inc;
  logic [LOG2_N:0]       ld_cnt;
  logic                  accept;
  logic                  emit;

  assign samp    = SW'(bus.in_data);
  assign acc_inc = acc + samp;
  assign cnt_inc = cnt + 1'b1;
  assign accept  = bus.in_valid && bus.in_ready;

  // block contents as of this edge, and whether
  // they leave now (full block or non-empty flush)
  always_comb begin
    ld_sum = accept ? acc_inc : acc;
    ld_cnt = accept ? cnt_inc : cnt;
    emit   = (state == FILL) &&
             ((accept && cnt_inc == N) ||
              (bus.flush && ld_cnt != '0));
  end

  formula_avg_shift #(
    .IN_W   (IN_W),
    .LOG2_N (LOG2_N)
  ) u_shift (
    .sum (ld_sum),
    .avg (ld_avg)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  // next state: emit a block, then wait handshake
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == FILL:
        if (emit) state_nx = EMIT;
      state == EMIT:
        if (bus.out_ready) state_nx = FILL;
    endcase
  end

  // handshake outputs decoded from state only
  always_comb begin
    bus.in_ready  = (state == FILL);
    bus.out_valid = (state == EMIT);
  end

  // accumulator and sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (emit) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_inc;
      cnt <= cnt_inc;
    end
  end

  // output registers hold until the next emit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_sum   <= '0;
      bus.out_avg   <= '0;
      bus.out_count <= '0;
    end else if (emit) begin
      bus.out_sum   <= ld_sum;
      bus.out_avg   <= ld_avg;
      bus.out_count <= ld_cnt;
    end
  end

endmodule

// File: tb/tb_formula_window_avg.sv
// tb_formula_window_avg: random and directed
// stimulus against a block-level model.
module tb_formula_window_avg;

  localparam int WIDTH  = 8;
  localparam int LOG2_N = 2;
  localparam int IN_W   = WIDTH * 2 + 3;
  localparam int N      = 1 << LOG2_N;

  logic clk = 1'b0;
  logic rst;

  formula_window_avg_if #(
    .WIDTH  (WIDTH),
    .LOG2_N (LOG2_N)
  ) bus ();

  formula_window_avg #(
    .WIDTH  (WIDTH),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  longint m_sum;
  int     m_cnt;
  bit     m_emit;
  longint e_sum;
  longint e_avg;
  longint e_cnt;

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic longint avg_of(
    input longint s
  );
    longint v;
    v = s;
`ifdef FORMULA_AVG_ROUND_EN
    if (LOG2_N > 0) v = v + N / 2;
`endif
    if (v >= 0) return v / N;
    return -((-v + N - 1) / N);
  endfunction

  task automatic check_all();
    check("in_ready", longint'(bus.in_ready),
          longint'(!m_emit));
    check("out_valid", longint'(bus.out_valid),
          longint'(m_emit));
    check("out_sum", bus.out_sum, e_sum);
    check("out_avg", bus.out_avg, e_avg);
    check("out_count", bus.out_count, e_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    m_sum = 0; m_cnt = 0; m_emit = 0;
    e_sum = 0; e_avg = 0; e_cnt = 0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic step(
    input bit     v,
    input longint d,
    input bit     f,
    input bit     r
  );
    bus.in_valid  = v;
    bus.in_data   = IN_W'(d);
    bus.flush     = f;
    bus.out_ready = r;
    @(posedge clk);
    if (!m_emit) begin
      if (v) begin
        m_sum += d;
        m_cnt++;
      end
      if ((v && m_cnt == N) ||
          (f && m_cnt > 0)) begin
        e_sum  = m_sum;
        e_cnt  = m_cnt;
        e_avg  = avg_of(m_sum);
        m_sum  = 0;
        m_cnt  = 0;
        m_emit = 1;
      end
    end else if (r) begin
      m_emit = 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  longint neg_avg;
  longint fl_avg;
  longint rd;

  initial begin
`ifdef FORMULA_AVG_ROUND_EN
    neg_avg = -6;
    fl_avg  = 2;
`else
    neg_avg = -7;
    fl_avg  = 1;
`endif
    do_reset();

    step(1, 10, 0, 1);
    step(1, 20, 0, 1);
    step(1, 30, 0, 1);
    step(1, 41, 0, 1);
    check("full_sum", bus.out_sum, 101);
    check("full_avg", bus.out_avg, 25);
    check("full_cnt", bus.out_count, 4);
    check("full_vld", longint'(bus.out_valid), 1);
    idle();
    check("full_rdy", longint'(bus.in_ready), 1);

    step(1, -5, 0, 1);
    step(1, -6, 0, 1);
    step(1, -7, 0, 1);
    step(1, -8, 0, 1);
    check("neg_sum", bus.out_sum, -26);
    check("neg_avg", bus.out_avg, neg_avg);
    idle();

    for (int i = 1; i <= 4; i++)
      step(1, i, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 100, 0, 0);
      check("bp_sum", bus.out_sum, 10);
      check("bp_rdy", longint'(bus.in_ready), 0);
    end
    step(1, 100, 0, 1);
    for (int i = 5; i <= 8; i++)
      step(1, i, 0, 1);
    check("bp_next", bus.out_sum, 26);
    idle();

    step(1, 1, 0, 1);
    step(1, 2, 0, 1);
    step(1, 3, 0, 1);
    step(0, 0, 1, 1);
    check("fl_sum", bus.out_sum, 6);
    check("fl_cnt", bus.out_count, 3);
    check("fl_avg", bus.out_avg, fl_avg);
    idle();
    step(0, 0, 1, 1);
    check("fl_empty", longint'(bus.out_valid), 0);
    step(1, 7, 0, 1);
    step(1, 9, 1, 1);
    check("fl_acc_sum", bus.out_sum, 16);
    check("fl_acc_cnt", bus.out_count, 2);
    idle();

    for (int i = 0; i < 4; i++)
      step(1, 262143, 0, 1);
    check("max_sum", bus.out_sum, 1048572);
    check("max_avg", bus.out_avg, 262143);
    idle();
    for (int i = 0; i < 4; i++)
      step(1, -262144, 0, 1);
    check("min_sum", bus.out_sum, -1048576);
    check("min_avg", bus.out_avg, -262144);
    idle();

    step(1, 50, 0, 1);
    step(1, 60, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 1);
    check("rst_sum", bus.out_sum, 4);
    idle();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rd = longint'($urandom_range(0, 524287))
             - 262144;
        if ($urandom_range(0, 3) == 0)
          rd = $urandom_range(0, 1) ?
               262143 : -262144;
        step($urandom_range(0, 3) != 0, rd,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 7);
      end
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
